// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The future receive path imports the same package.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Register-side bundle between the MMIO block and the UART transmit sequencer.
// The master drives the data register and the overflow clear; the slave returns the pin and status flags.
interface uart_tx_ctrl_if;
    logic [8:0] uart_tx_data;
    logic       overflow_clr;
    logic       tx;
    logic       uart_tx_sending;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output uart_tx_data, overflow_clr,
        input  tx, uart_tx_sending, fifo_full, overflow
    );

    modport slave (
        input  uart_tx_data, overflow_clr,
        output tx, uart_tx_sending, fifo_full, overflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. A push into a full FIFO is accepted
// only when a pop happens in the same cycle. The read head is visible combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem[rd_ptr_q[AW-1:0]];

    // NOTE: assign every _d a default before any branch so always_comb never infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: use non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: leave the storage array out of reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// Serial-transmit sequencer: turns toggle-tagged MMIO writes into queued bytes
// and shifts them out as back-to-back 8N1 frames on tx.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  bus
);
    localparam int                        CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int                        IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0]          CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]          LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

    uart_tx_state_e              state_q, state_d;
    logic                        tx_q, tx_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        last_toggle_q, last_toggle_d;
    logic                        overflow_q, overflow_d;

    logic                        push, pop, drop;
    logic                        fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_rdata;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.uart_tx_data[7:0]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Every flip of bit 8 is one CPU write, including flips on consecutive cycles.
    assign push          = bus.uart_tx_data[8] != last_toggle_q;
    assign drop          = push && fifo_full && !pop;
    assign last_toggle_d = bus.uart_tx_data[8];
    assign overflow_d    = drop ? 1'b1 : (bus.overflow_clr ? 1'b0 : overflow_q);

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_q          <= 1'b1;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            last_toggle_q <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            last_toggle_q <= last_toggle_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.tx              = tx_q;
    assign bus.overflow        = overflow_q;
    assign bus.fifo_full       = fifo_full;
    assign bus.uart_tx_sending = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a queue/frame-timer reference model predicts accepted bytes and line levels,
// and a serial receiver monitor pops the expected-byte scoreboard as frames arrive on tx.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = UART_FRAME_BITS * CPB;

    logic clk;
    logic rst_n;
    logic tog;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: queued bytes, remaining cycles of the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         m_left;
    logic [9:0] m_frame;
    logic       m_last_tog;
    logic       m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_bitpos();
        return (FRAME_CYC - m_left) / CPB;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, stepped on each rising edge from the bench-driven inputs.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                exp_q.delete();
                m_left     = 0;
                m_frame    = '1;
                m_last_tog = 1'b1;
                m_ov       = 1'b0;
            end else begin
                logic p, popped, dropped;
                p          = bus.uart_tx_data[8] != m_last_tog;
                m_last_tog = bus.uart_tx_data[8];
                popped     = (m_left <= 1) && (m_q.size() > 0);
                if (popped) begin
                    m_frame = {1'b1, m_q.pop_front(), 1'b0};
                    m_left  = FRAME_CYC;
                end else if (m_left > 0) begin
                    m_left--;
                end
                dropped = 1'b0;
                if (p) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(bus.uart_tx_data[7:0]);
                        exp_q.push_back(bus.uart_tx_data[7:0]);
                    end else begin
                        dropped = 1'b1;
                    end
                end
                if (dropped) m_ov = 1'b1;
                else if (bus.overflow_clr) m_ov = 1'b0;
            end
        end
    end

    // Cycle-level comparison of pin and flags against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("tx_level", bus.tx, (m_left == 0) ? 1'b1 : m_frame[m_bitpos()]);
            check("sending", bus.uart_tx_sending, (m_left > 0) || (m_q.size() > 0));
            check("fifo_full", bus.fifo_full, m_q.size() == DEPTH);
            check("overflow", bus.overflow, m_ov);
        end
    end

    // Serial receiver monitor: decodes frames at mid-bit and pops the scoreboard.
    initial begin
        logic       busy;
        int         cnt;
        logic [7:0] rx;
        busy = 1'b0;
        cnt  = 0;
        rx   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (!busy && bus.tx == 1'b0) begin
                    busy = 1'b1;
                    cnt  = 0;
                end
                if (busy) begin
                    if (cnt % CPB == CPB / 2) begin
                        int k;
                        k = cnt / CPB;
                        if (k == 0) begin
                            check("rx_start_bit", bus.tx, 1'b0);
                        end else if (k <= UART_DATA_BITS) begin
                            rx[k-1] = bus.tx;
                        end else begin
                            check("rx_stop_bit", bus.tx, 1'b1);
                            if (exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL rx_unexpected: got byte 0x%0h expected no frame at %0t", rx, $time);
                            end else begin
                                check("rx_byte", rx, exp_q.pop_front());
                            end
                            busy = 1'b0;
                        end
                    end
                    cnt++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        tog                = ~tog;
        bus.uart_tx_data   = {tog, b};
    endtask

    task automatic send_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            send(first + 8'(i));
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.uart_tx_sending && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", bus.uart_tx_sending, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.overflow_clr = 1'b1;
        @(negedge clk);
        bus.overflow_clr = 1'b0;
    endtask

    initial begin
        int n;
        rst_n            = 1'b0;
        tog              = 1'b1;
        bus.uart_tx_data = 9'h1FF;
        bus.overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", bus.tx, 1'b1);
        check("reset_sending", bus.uart_tx_sending, 1'b0);
        check("reset_full", bus.fifo_full, 1'b0);
        check("reset_overflow", bus.overflow, 1'b0);

        // Single byte 0x55.
        @(negedge clk);
        send(8'h55);
        wait_idle(200);

        // Back-to-back frames.
        send_burst(8'h41, 2);
        wait_idle(300);

        // Overflow: 0x10..0x15 on consecutive cycles, 0x15 dropped.
        send_burst(8'h10, 6);
        @(negedge clk);
        check("ovf_full", bus.fifo_full, 1'b1);
        check("ovf_set", bus.overflow, 1'b1);
        pulse_clr();
        check("ovf_cleared", bus.overflow, 1'b0);
        bus.overflow_clr = 1'b1;
        send(8'h16);
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        check("ovf_set_beats_clr", bus.overflow, 1'b1);
        pulse_clr();
        wait_idle(600);

        // Push while full on the exact STOP->START pop cycle.
        send_burst(8'h20, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_left != 1 && n < 200);
        check("pop_cycle_found", m_left, 1);
        check("full_before_pop", bus.fifo_full, 1'b1);
        send(8'h25);
        @(negedge clk);
        check("full_pop_no_ovf", bus.overflow, 1'b0);
        wait_idle(600);

        // Reset during DATA bit 3 with more bytes queued.
        send_burst(8'hA5, 3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_left > 0 && m_bitpos() == 4) && n < 200);
        check("data_bit3_found", m_bitpos(), 4);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tx", bus.tx, 1'b1);
        check("abort_sending", bus.uart_tx_sending, 1'b0);
        check("abort_full", bus.fifo_full, 1'b0);
        repeat (3) @(negedge clk);
        tog              = 1'b1;
        bus.uart_tx_data = {1'b1, 8'h3C};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_reset_idle", bus.uart_tx_sending, 1'b0);

        // Low byte changes without a toggle must not send.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.uart_tx_data = {tog, 8'($urandom)};
        end
        check("no_false_push", bus.uart_tx_sending, 1'b0);

        // Randomized writes and clear pulses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) send(8'($urandom));
            bus.overflow_clr = ($urandom_range(0, 15) == 0);
        end
        @(negedge clk);
        bus.overflow_clr = 1'b0;
        wait_idle(2000);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
